// File: rtl/cska_pkg.sv
// Shared definitions for the carry-skip adder slice and its word-serial sequencer.
package cska_pkg;

  // Sequencer state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  // Chunk counter width: enough to hold CHUNKS-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned chunks);
    return (chunks <= 1) ? 1 : $clog2(chunks);
  endfunction

endpackage

// File: rtl/cska_top.sv
// N-bit carry-skip adder slice: ripple inside each skip block, and a block whose
// bits all propagate passes its incoming carry straight to the next block.
module cska_top #(
  parameter int unsigned N          = 4,
  parameter int unsigned BLOCK_SIZE = 2
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int unsigned NB = N / BLOCK_SIZE;

  // Block-wise ripple with skip multiplexer on each block's carry-out
  always_comb begin
    logic carry;
    logic blk_cin;
    logic blk_p;
    logic p;
    sum     = '0;
    carry   = cin;
    blk_cin = 1'b0;
    blk_p   = 1'b0;
    p       = 1'b0;
    for (int k = 0; k < int'(NB); k++) begin
      blk_cin = carry;
      blk_p   = 1'b1;
      for (int j = 0; j < int'(BLOCK_SIZE); j++) begin
        p = a[k*BLOCK_SIZE + j] ^ b[k*BLOCK_SIZE + j];
        sum[k*BLOCK_SIZE + j] = p ^ carry;
        carry = (a[k*BLOCK_SIZE + j] & b[k*BLOCK_SIZE + j]) | (p & carry);
        blk_p = blk_p & p;
      end
      carry = blk_p ? blk_cin : carry;
    end
    cout = carry;
  end

endmodule

// File: rtl/cska_serial_ctrl.sv
// Word-serial wide adder: one N-bit carry-skip slice reused over CHUNKS cycles,
// least-significant chunk first, with the chunk carry held in carry_r.
module cska_serial_ctrl
  import cska_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned BLOCK_SIZE = 2,
  parameter int unsigned CHUNKS     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*CHUNKS-1:0]   a,
  input  logic [N*CHUNKS-1:0]   b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*CHUNKS-1:0]   sum,
  output logic                  cout
);

  localparam int unsigned WIDE = N * CHUNKS;
  localparam int unsigned CW   = cnt_width(CHUNKS);

  state_e          state;
  logic [WIDE-1:0] a_sh;
  logic [WIDE-1:0] b_sh;
  logic [WIDE-1:0] sum_sh;
  logic            carry_r;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    slice_sum;
  logic            slice_cout;

  cska_top #(
    .N          (N),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_slice (
    .a    (a_sh[N-1:0]),
    .b    (b_sh[N-1:0]),
    .cin  (carry_r),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Result is read straight from the accumulated registers
  assign sum  = sum_sh;
  assign cout = carry_r;

  // Sequencer: state, handshake flags, chunk counter and shift registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry_r   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            carry_r  <= cin;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
          end
        end
        RUN: begin
          sum_sh  <= WIDE'({slice_sum, sum_sh} >> N);
          a_sh    <= a_sh >> N;
          b_sh    <= b_sh >> N;
          carry_r <= slice_cout;
          if (cnt == CW'(CHUNKS - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cska_serial_ctrl.sv
// Self-checking bench for cska_serial_ctrl with N=4, BLOCK_SIZE=2, CHUNKS=4.
module tb_cska_serial_ctrl;

  localparam int unsigned N      = 4;
  localparam int unsigned BS     = 2;
  localparam int unsigned CHUNKS = 4;
  localparam int unsigned WIDE   = N * CHUNKS;

  typedef struct packed {
    logic [WIDE-1:0] sum;
    logic            cout;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [WIDE-1:0] a;
  logic [WIDE-1:0] b;
  logic            cin;
  logic            out_valid;
  logic            out_ready;
  logic [WIDE-1:0] sum;
  logic            cout;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t q[$];

  cska_serial_ctrl #(
    .N          (N),
    .BLOCK_SIZE (BS),
    .CHUNKS     (CHUNKS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference result of the wide addition
  function automatic exp_t model(input logic [WIDE-1:0] x, input logic [WIDE-1:0] y, input logic c);
    logic [WIDE:0] t;
    exp_t e;
    t = {1'b0, x} + {1'b0, y} + {{WIDE{1'b0}}, c};
    e.sum  = t[WIDE-1:0];
    e.cout = t[WIDE];
    return e;
  endfunction

  // Present an operand set until accepted; acc is the cycle count after the accept edge
  task automatic send_op(input logic [WIDE-1:0] av, input logic [WIDE-1:0] bv, input logic cv,
                         output int acc, output bit ok);
    int budget;
    bit rdy;
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    budget = 0; rdy = 1'b0;
    while (!rdy && budget < 40) begin
      rdy = in_ready;
      @(posedge clk); #1;
      budget++;
    end
    in_valid = 1'b0;
    acc = cyc;
    ok = rdy;
  endtask

  // Wait (bounded) for out_valid; sampled 1 time unit after an edge
  task automatic wait_out(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (sum !== '0) begin failures++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [WIDE-1:0] ta [4] = '{16'h0000, 16'hFFFF, 16'h00FF, 16'hFFFF};
    logic [WIDE-1:0] tbv[4] = '{16'h0000, 16'hFFFF, 16'h0001, 16'h0001};
    logic            tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int acc; bit ok; bit got; exp_t e;
    for (int k = 0; k < 4; k++) begin
      q.push_back(model(ta[k], tbv[k], tc[k]));
      send_op(ta[k], tbv[k], tc[k], acc, ok);
      checks++; if (!ok) begin failures++; $display("FAIL vec%0d_accept got=timeout exp=accepted", k); end
      wait_out(got);
      e = q.pop_front();
      checks++; if (!got) begin failures++; $display("FAIL vec%0d_out_valid got=timeout exp=valid", k); end
      checks++; if (cyc - acc != int'(CHUNKS)) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=%0d", k, cyc - acc, CHUNKS); end
      checks++; if (sum !== e.sum) begin failures++; $display("FAIL vec%0d_sum got=%h exp=%h", k, sum, e.sum); end
      checks++; if (cout !== e.cout) begin failures++; $display("FAIL vec%0d_cout got=%b exp=%b", k, cout, e.cout); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL vec%0d_valid_drop got=%b exp=0", k, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    int acc; bit ok; bit got; exp_t e;
    out_ready = 1'b0;
    q.push_back(model(16'hABCD, 16'h1111, 1'b1));
    send_op(16'hABCD, 16'h1111, 1'b1, acc, ok);
    wait_out(got);
    checks++; if (!got) begin failures++; $display("FAIL bp_out_valid got=timeout exp=valid"); end
    // A second request shows up while the first result is stalled
    a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
    e = q.pop_front();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (sum !== e.sum) begin failures++; $display("FAIL bp_hold%0d_sum got=%h exp=%h", i, sum, e.sum); end
      checks++; if (cout !== e.cout) begin failures++; $display("FAIL bp_hold%0d_cout got=%b exp=%b", i, cout, e.cout); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold%0d_in_ready got=%b exp=0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold%0d_out_valid got=%b exp=1", i, out_valid); end
    end
    out_ready = 1'b1;
    q.push_back(model(16'h1234, 16'h4321, 1'b0));
    send_op(16'h1234, 16'h4321, 1'b0, acc, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_second_accept got=timeout exp=accepted"); end
    wait_out(got);
    e = q.pop_front();
    checks++; if (!got) begin failures++; $display("FAIL bp_second_valid got=timeout exp=valid"); end
    checks++; if (sum !== e.sum) begin failures++; $display("FAIL bp_second_sum got=%h exp=%h", sum, e.sum); end
    checks++; if (cout !== e.cout) begin failures++; $display("FAIL bp_second_cout got=%b exp=%b", cout, e.cout); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int acc; bit ok; bit got; bit saw; exp_t e;
    send_op(16'hFFFF, 16'h0001, 1'b0, acc, ok);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_run_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_run_out_valid got=%b exp=0", out_valid); end
    @(posedge clk); #1 rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    checks++; if (saw) begin failures++; $display("FAIL rst_run_no_pulse got=pulse exp=none"); end
    q.push_back(model(16'h8000, 16'h8000, 1'b0));
    send_op(16'h8000, 16'h8000, 1'b0, acc, ok);
    wait_out(got);
    e = q.pop_front();
    checks++; if (!got) begin failures++; $display("FAIL rst_next_valid got=timeout exp=valid"); end
    checks++; if (sum !== e.sum) begin failures++; $display("FAIL rst_next_sum got=%h exp=%h", sum, e.sum); end
    checks++; if (cout !== e.cout) begin failures++; $display("FAIL rst_next_cout got=%b exp=%b", cout, e.cout); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int acc; int prev; bit ok; bit got; exp_t e;
    logic [WIDE-1:0] x; logic [WIDE-1:0] y; logic c;
    prev = -1;
    for (int k = 0; k < 8; k++) begin
      x = WIDE'($urandom); y = WIDE'($urandom); c = 1'($urandom_range(0, 1));
      q.push_back(model(x, y, c));
      send_op(x, y, c, acc, ok);
      if (prev >= 0) begin
        checks++; if (acc - prev != int'(CHUNKS) + 2) begin failures++; $display("FAIL b2b%0d_interval got=%0d exp=%0d", k, acc - prev, CHUNKS + 2); end
      end
      prev = acc;
      wait_out(got);
      e = q.pop_front();
      checks++; if (!got) begin failures++; $display("FAIL b2b%0d_valid got=timeout exp=valid", k); end
      checks++; if (sum !== e.sum) begin failures++; $display("FAIL b2b%0d_sum got=%h exp=%h a=%h b=%h cin=%b", k, sum, e.sum, x, y, c); end
      checks++; if (cout !== e.cout) begin failures++; $display("FAIL b2b%0d_cout got=%b exp=%b", k, cout, e.cout); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
